// File: rtl/uart_inst_rx.sv
// UART 8N1 receiver that pairs two bytes (high byte first) into a 16-bit instruction word
// for the fetch-stage override port; an unpaired high byte is dropped after WORD_TIMEOUT idle clocks.
//   state   | meaning
//   S_IDLE  | line idle, waiting for a low level on the synchronized rx
//   S_START | timing to the start-bit mid-point, rejects glitches
//   S_DATA  | shifting in 8 data bits, LSB first
//   S_STOP  | sampling the stop bit, then accept the byte or flag a frame error
module uart_inst_rx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int WORD_TIMEOUT = 8 * CLKS_PER_BIT * 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_rx,
   output logic [15:0] o_inst,
   output logic        o_inst_en,
   output logic        o_frame_err,
   output logic        o_busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int TO_W  = $clog2(WORD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(WORD_TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t             r_state;
   logic               r_rx_meta;
   logic               r_rx_sync;
   logic [CNT_W-1:0]   r_clk_cnt;
   logic [2:0]         r_bit_cnt;
   logic [7:0]         r_shift;
   logic               r_hi_valid;
   logic [7:0]         r_hi_byte;
   logic [TO_W-1:0]    r_to_cnt;

   assign o_busy = (r_state != S_IDLE) || r_hi_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_rx_meta   <= 1'b1;
         r_rx_sync   <= 1'b1;
         r_clk_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_hi_valid  <= 1'b0;
         r_hi_byte   <= '0;
         r_to_cnt    <= '0;
         o_inst      <= '0;
         o_inst_en   <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         r_rx_meta   <= i_rx;
         r_rx_sync   <= r_rx_meta;
         o_inst_en   <= 1'b0;
         o_frame_err <= 1'b0;

         // Pending high byte ages only while the line is idle; counter saturates at the limit.
         if (r_state == S_IDLE && r_hi_valid) begin
            if (r_to_cnt == TO_MAX) begin
               r_hi_valid <= 1'b0;
            end else begin
               r_to_cnt <= r_to_cnt + TO_W'(1);
            end
         end

         case (r_state)
            S_IDLE: begin
               if (!r_rx_sync) begin
                  r_state   <= S_START;
                  r_clk_cnt <= '0;
                  r_bit_cnt <= '0;
               end
            end
            S_START: begin
               if (r_clk_cnt == HALF_M1) begin
                  r_clk_cnt <= '0;
                  r_state   <= r_rx_sync ? S_IDLE : S_DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (r_clk_cnt == FULL_M1) begin
                  r_clk_cnt <= '0;
                  r_shift   <= {r_rx_sync, r_shift[7:1]};
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= S_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end
            S_STOP: begin
               if (r_clk_cnt == FULL_M1) begin
                  r_clk_cnt <= '0;
                  r_state   <= S_IDLE;
                  if (r_rx_sync) begin
                     if (r_hi_valid) begin
                        o_inst     <= {r_hi_byte, r_shift};
                        o_inst_en  <= 1'b1;
                        r_hi_valid <= 1'b0;
                     end else begin
                        r_hi_byte  <= r_shift;
                        r_hi_valid <= 1'b1;
                        r_to_cnt   <= '0;
                     end
                  end else begin
                     // Bad stop bit: drop the byte and resync so the next good byte is a high byte.
                     o_frame_err <= 1'b1;
                     r_hi_valid  <= 1'b0;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CNT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_inst_rx.sv
// Bench for uart_inst_rx: byte-level model of word pairing, per-cycle output compare,
// and literal expectations for each directed scenario.
module tb_uart_inst_rx;
   localparam int CPB = 4;
   localparam int WT  = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_rx = 1'b1;
   logic [15:0] o_inst;
   logic        o_inst_en;
   logic        o_frame_err;
   logic        o_busy;

   uart_inst_rx #(.CLKS_PER_BIT(CPB), .WORD_TIMEOUT(WT)) dut (
      .clk(clk), .reset(reset), .i_rx(i_rx),
      .o_inst(o_inst), .o_inst_en(o_inst_en),
      .o_frame_err(o_frame_err), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Byte-level model: which words and frame errors the sent bytes must produce.
   logic [15:0] exp_q[$];
   int          exp_err_pend = 0;
   bit          m_hi_valid = 1'b0;
   logic [7:0]  m_hi_byte = 8'h00;
   int          n_inst = 0;
   int          n_err = 0;
   logic [15:0] last_inst = 16'h0000;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            chk("reset_inst", 32'(o_inst), 0);
            chk("reset_inst_en", 32'(o_inst_en), 0);
            chk("reset_frame_err", 32'(o_frame_err), 0);
            chk("reset_busy", 32'(o_busy), 0);
            last_inst = 16'h0000;
         end else begin
            chk("strobe_exclusive", 32'(o_inst_en & o_frame_err), 0);
            if (o_inst_en) begin
               n_inst++;
               if (exp_q.size() == 0) chk("spurious_strobe", 32'(o_inst), -1);
               else chk("inst_word", 32'(o_inst), 32'(exp_q.pop_front()));
               last_inst = o_inst;
            end else begin
               chk("inst_hold", 32'(o_inst), 32'(last_inst));
            end
            if (o_frame_err) begin
               n_err++;
               chk("frame_err_expected", (exp_err_pend > 0) ? 1 : 0, 1);
               if (exp_err_pend > 0) exp_err_pend--;
            end
         end
      end
   end

   task automatic send_bit(input logic v);
      i_rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_ok);
      i_rx = 1'b1;
      if (!stop_ok) begin
         exp_err_pend++;
         m_hi_valid = 1'b0;
      end else if (m_hi_valid) begin
         exp_q.push_back({m_hi_byte, b});
         m_hi_valid = 1'b0;
      end else begin
         m_hi_byte  = b;
         m_hi_valid = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      i_rx = 1'b1;
      repeat (n) @(negedge clk);
      if (n >= WT + 2 * CPB) m_hi_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int t = 0;
      while ((exp_q.size() != 0 || exp_err_pend != 0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk(name, exp_q.size() + exp_err_pend, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int e0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_busy", 32'(o_busy), 0);
      chk("post_reset_inst", 32'(o_inst), 0);

      // Two bytes, one idle bit between them
      p0 = n_inst; e0 = n_err;
      send_byte(8'h12, 1'b1);
      idle(CPB);
      send_byte(8'h34, 1'b1);
      idle(3 * CPB);
      drain("s1_drain");
      chk("s1_pulses", n_inst - p0, 1);
      chk("s1_word", 32'(o_inst), 32'h1234);
      chk("s1_no_err", n_err - e0, 0);

      // Four bytes back to back
      p0 = n_inst; e0 = n_err;
      send_byte(8'hAB, 1'b1);
      send_byte(8'hCD, 1'b1);
      send_byte(8'hEF, 1'b1);
      send_byte(8'h01, 1'b1);
      idle(3 * CPB);
      drain("s2_drain");
      chk("s2_pulses", n_inst - p0, 2);
      chk("s2_word", 32'(o_inst), 32'hEF01);
      chk("s2_no_err", n_err - e0, 0);

      // One-clock glitch on the line
      p0 = n_inst; e0 = n_err;
      i_rx = 1'b0;
      @(negedge clk);
      i_rx = 1'b1;
      repeat (2) @(negedge clk);
      chk("glitch_busy_rise", 32'(o_busy), 1);
      repeat (3) @(negedge clk);
      chk("glitch_busy_low", 32'(o_busy), 0);
      idle(2 * CPB);
      chk("glitch_pulses", n_inst - p0, 0);
      chk("glitch_err", n_err - e0, 0);

      // Bad stop bit then a good word
      p0 = n_inst; e0 = n_err;
      send_byte(8'h55, 1'b0);
      idle(3 * CPB);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      idle(3 * CPB);
      drain("s4_drain");
      chk("s4_err_pulses", n_err - e0, 1);
      chk("s4_pulses", n_inst - p0, 1);
      chk("s4_word", 32'(o_inst), 32'h1234);

      // Orphan high byte times out
      p0 = n_inst; e0 = n_err;
      send_byte(8'h77, 1'b1);
      idle(150);
      chk("timeout_busy", 32'(o_busy), 0);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      idle(3 * CPB);
      drain("s5_drain");
      chk("s5_pulses", n_inst - p0, 1);
      chk("s5_word", 32'(o_inst), 32'h1234);
      chk("s5_no_err", n_err - e0, 0);

      // Reset during data bits of the low byte of 0x9876
      p0 = n_inst;
      send_byte(8'h98, 1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      reset = 1'b1;
      i_rx  = 1'b1;
      m_hi_valid = 1'b0;
      exp_q.delete();
      exp_err_pend = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("s6_reset_inst", 32'(o_inst), 0);
      chk("s6_reset_en", 32'(o_inst_en), 0);
      chk("s6_reset_busy", 32'(o_busy), 0);
      idle(2 * CPB);
      chk("s6_no_pulse", n_inst - p0, 0);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      idle(3 * CPB);
      drain("s6_drain");
      chk("s6_pulses", n_inst - p0, 1);
      chk("s6_word", 32'(o_inst), 32'h1234);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
